// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline and memory-port signal bundle for mem_port_arbiter
//
// Ports (interface signals):
//   inst_*      fetch side:  req/addr in, rdata/stall out
//   data_*      data side:   req/wr/wstrb/addr/wdata in, rdata/stall out
//   pipe_adv    pipeline advances this cycle (clears done flags)
//   flush       redirect, cancels the current fetch
//   bus_*       sram-like memory port
// Modports:
//   master      the arbiter's view
//   slave       the pipeline + memory view
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        pipe_adv;
  logic        flush;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  pipe_adv, flush, bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_rdata, inst_stall, data_rdata, data_stall,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );

  modport slave (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output pipe_adv, flush, bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_rdata, inst_stall, data_rdata, data_stall,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one sram-like port between fetch and data access
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   port           mem_port_arbiter_if.master (pipeline sides + memory bus)
//   inst_wait_cnt  cycles with inst_stall high (only with MEM_ARB_PERF_CNT_EN)
//   data_wait_cnt  cycles with data_stall high (only with MEM_ARB_PERF_CNT_EN)
// Parameters:
//   DATA_FIRST     1: data side wins a tie in IDLE, 0: fetch side wins
// Optional feature macro: MEM_ARB_PERF_CNT_EN
module mem_port_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   port
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          inst_wait_cnt,
  output logic [31:0]          data_wait_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        cancel_q, cancel_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        bus_wr_q, bus_wr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic inst_pend, data_pend, pick_data;
  logic inst_set, data_set;

  assign inst_pend = port.inst_req & ~inst_done_q;
  assign data_pend = port.data_req & ~data_done_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancel_d     = cancel_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    bus_wr_d     = bus_wr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_set     = 1'b0;
    data_set     = 1'b0;
    pick_data    = data_pend & (DATA_FIRST | ~inst_pend);

    // A redirect while a fetch is on the bus marks its response for discard.
    // Placed ahead of the FSM so a completion in the same cycle clears it.
    if (port.flush && owner_q == OWN_INST && state_q != S_IDLE) begin
      cancel_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (inst_pend || data_pend) begin
          state_d = S_ADDR;
          if (pick_data) begin
            owner_d     = OWN_DATA;
            bus_wr_d    = port.data_wr;
            bus_wstrb_d = port.data_wstrb;
            bus_addr_d  = port.data_addr;
            bus_wdata_d = port.data_wdata;
          end else begin
            owner_d     = OWN_INST;
            bus_wr_d    = 1'b0;
            bus_wstrb_d = 4'b0000;
            bus_addr_d  = port.inst_addr;
            bus_wdata_d = 32'h0;
          end
        end
      end
      S_ADDR: begin
        if (port.bus_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (port.bus_data_ok) begin
          state_d  = S_IDLE;
          cancel_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            data_set = 1'b1;
            if (!bus_wr_q) begin
              data_rdata_d = port.bus_rdata;
            end
          end else if (!cancel_q && !port.flush) begin
            // A flush arriving with the response also makes it stale.
            inst_set     = 1'b1;
            inst_rdata_d = port.bus_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Setting a done flag beats clearing it in the same cycle.
    inst_done_d = inst_done_q;
    if (port.pipe_adv || port.flush) inst_done_d = 1'b0;
    if (inst_set) inst_done_d = 1'b1;

    data_done_d = data_done_q;
    if (port.pipe_adv) data_done_d = 1'b0;
    if (data_set) data_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      cancel_q     <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      bus_wr_q     <= 1'b0;
      bus_wstrb_q  <= 4'b0000;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cancel_q     <= cancel_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      bus_wr_q     <= bus_wr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign port.inst_stall = inst_pend;
  assign port.data_stall = data_pend;
  assign port.inst_rdata = inst_rdata_q;
  assign port.data_rdata = data_rdata_q;
  assign port.bus_req    = (state_q == S_ADDR);
  assign port.bus_wr     = bus_wr_q;
  assign port.bus_wstrb  = bus_wstrb_q;
  assign port.bus_addr   = bus_addr_q;
  assign port.bus_wdata  = bus_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] inst_wait_q, data_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_wait_q <= 32'h0;
      data_wait_q <= 32'h0;
    end else begin
      if (inst_pend) inst_wait_q <= inst_wait_q + 32'd1;
      if (data_pend) data_wait_q <= data_wait_q + 32'd1;
    end
  end

  assign inst_wait_cnt = inst_wait_q;
  assign data_wait_cnt = data_wait_q;
`endif

endmodule
